// File: rtl/umem_pkg.sv
// rtl/umem_pkg.sv - shared constants and state type for the unified memory responder
package umem_pkg;

  // RISC-V load/store funct3 encodings accepted by the responder
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of the wait-state counter (WAIT_STATES is limited to 0..15)
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } umem_state_e;

endpackage

// File: rtl/umem_lane_align.sv
// rtl/umem_lane_align.sv - byte-lane steering for stores and lane select/extension for loads
module umem_lane_align
  import umem_pkg::*;
(
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store path: replicate the right-aligned data into every lane, byte enables pick the target
  always_comb begin
    be    = 4'b0000;
    wword = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata;
      end
    endcase
  end

  // Load path: select the addressed lane, then sign- or zero-extend by funct3
  always_comb begin
    byte_sel = 8'h0;
    case (addr_lo)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    rdata    = 32'h0;
    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {24'h0, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata = {16'h0, half_sel};
      F3_W:    rdata = rword;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/unified_mem_responder.sv
// rtl/unified_mem_responder.sv - variable-latency load/store memory responder (option: UMEM_ALIGN_CHECK_EN)
module unified_mem_responder
  import umem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;

  umem_state_e state, state_next;
  logic [WAIT_W-1:0] wait_cnt;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;

  logic [31:0] mem [DEPTH];

  logic              f3_illegal;
  logic              access_err;
  logic [1:0]        addr_lo;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       ldata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
      end
      WAIT: begin
        if (wait_cnt == '0) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = RESP;
      end
      default: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down while waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE && req_valid) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Request latch; the initiator may drop its inputs right after acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
    end else if (state == IDLE && req_valid) begin
      we_q     <= req_we;
      addr_q   <= req_addr;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
    end
  end

  // Request decode: illegal funct3 always errors; alignment is checked or forced
  always_comb begin
    f3_illegal = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11) || (we_q && funct3_q[2]);
`ifdef UMEM_ALIGN_CHECK_EN
    addr_lo    = addr_q[1:0];
    access_err = f3_illegal
               || (funct3_q[1:0] == 2'b01 && addr_q[0])
               || (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
    access_err = f3_illegal;
    case (funct3_q[1:0])
      2'b01:   addr_lo = {addr_q[1], 1'b0};
      2'b10:   addr_lo = 2'b00;
      default: addr_lo = addr_q[1:0];
    endcase
`endif
  end

  assign word_idx = addr_q[ADDR_W-1:2];
  assign rword    = mem[word_idx];

  umem_lane_align u_lane_align (
    .wdata   (wdata_q),
    .addr_lo (addr_lo),
    .funct3  (funct3_q),
    .rword   (rword),
    .be      (be),
    .wword   (wword),
    .rdata   (ldata)
  );

  // Array write during ACCESS so the store is visible to the next request
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Response capture in ACCESS, held stable through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_err   <= access_err;
      rsp_rdata <= (access_err || we_q) ? 32'h0 : ldata;
    end
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
// tb/tb_unified_mem_responder.sv - directed bench for unified_mem_responder (WAIT_STATES=2, honours UMEM_ALIGN_CHECK_EN)
module tb_unified_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors     = 0;
  int miscompares = 0;

  unified_mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // Presents one request, returns the response and the cycles from presentation to rsp_valid
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = 32'hX;
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 50);
    rd = rsp_rdata;
    er = rsp_err;
    if (lat >= 50) begin
      vectors++; miscompares++;
      $display("FAIL timeout addr=%h f3=%b: no rsp_valid within 50 cycles", addr, f3);
    end
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h0;
    req_funct3 = 3'b000; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 8'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL sw_latency got %0d exp 4", lat); end
    vectors++; if (er !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL sw_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    do_req(1'b0, 8'h10, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL lw_latency got %0d exp 4", lat); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_10 got %h exp deadbeef", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL lw_10_err got %b exp 0", er); end
  endtask

  task automatic test_subword_load();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 8'h13, 3'b000, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hFFFFFFDE) begin miscompares++; $display("FAIL lb_13 got %h exp ffffffde", rd); end
    do_req(1'b0, 8'h13, 3'b100, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h000000DE) begin miscompares++; $display("FAIL lbu_13 got %h exp 000000de", rd); end
    do_req(1'b0, 8'h12, 3'b001, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hFFFFDEAD) begin miscompares++; $display("FAIL lh_12 got %h exp ffffdead", rd); end
    do_req(1'b0, 8'h10, 3'b101, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu_10 got %h exp 0000beef", rd); end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 8'h11, 3'b000, 32'h12345677, rd, er, lat);
    do_req(1'b0, 8'h10, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hDEAD77EF) begin miscompares++; $display("FAIL sb_11 got %h exp dead77ef", rd); end
    do_req(1'b1, 8'h12, 3'b001, 32'hAAAA5555, rd, er, lat);
    do_req(1'b0, 8'h10, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h555577EF) begin miscompares++; $display("FAIL sh_12 got %h exp 555577ef", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
`ifdef UMEM_ALIGN_CHECK_EN
    do_req(1'b0, 8'h11, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL lw_11_misalign got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    do_req(1'b1, 8'h13, 3'b001, 32'h0000FFFF, rd, er, lat);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL sh_13_misalign got err=%b exp 1", er); end
    do_req(1'b0, 8'h10, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h555577EF) begin miscompares++; $display("FAIL sh_13_nowrite got %h exp 555577ef", rd); end
`else
    do_req(1'b0, 8'h11, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (er !== 1'b0 || rd !== 32'h555577EF) begin miscompares++; $display("FAIL lw_11_forced got err=%b rdata=%h exp err=0 rdata=555577ef", er, rd); end
    do_req(1'b0, 8'h13, 3'b101, 32'h0, rd, er, lat);
    vectors++; if (er !== 1'b0 || rd !== 32'h00005555) begin miscompares++; $display("FAIL lhu_13_forced got err=%b rdata=%h exp err=0 rdata=00005555", er, rd); end
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 8'h10, 3'b011, 32'h0, rd, er, lat);
    vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL f3_011_load got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    do_req(1'b0, 8'h10, 3'b110, 32'h0, rd, er, lat);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL f3_110_load got err=%b exp 1", er); end
    do_req(1'b1, 8'h10, 3'b100, 32'h11111111, rd, er, lat);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL f3_100_store got err=%b exp 1", er); end
    do_req(1'b0, 8'h10, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h555577EF) begin miscompares++; $display("FAIL f3_100_nowrite got %h exp 555577ef", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h10, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h555577EF) begin miscompares++; $display("FAIL bp_first got %h exp 555577ef", rd); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h555577EF || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h ready=%b exp valid=1 rdata=555577ef ready=0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_funct3 = 3'b010; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_no_rsp cycle %0d got valid=%b exp 0", i, rsp_valid); end
    end
    do_req(1'b0, 8'h10, 3'b010, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h555577EF) begin miscompares++; $display("FAIL rst_wait_nowrite got %h exp 555577ef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 8'h14, 3'b010, 32'h0BADF00D, rd, er, lat);
    do_req(1'b0, 8'h14, 3'b000, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h0000000D) begin miscompares++; $display("FAIL b2b_lb_14 got %h exp 0000000d", rd); end
    do_req(1'b0, 8'h16, 3'b001, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h00000BAD) begin miscompares++; $display("FAIL b2b_lh_16 got %h exp 00000bad", rd); end
    do_req(1'b0, 8'h15, 3'b000, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hFFFFFFF0) begin miscompares++; $display("FAIL b2b_lb_15 got %h exp fffffff0", rd); end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL b2b_latency got %0d exp 4", lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_load();
    test_subword_store();
    test_misalign();
    test_illegal();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
